// File: rtl/sequenciador_delta.sv
// Multi-cycle |b^2 - c*2^SHIFT| datapath built around one shared shift-add multiplier.
// A start/done handshake drives it; s and neg stay valid from the done pulse until the next SUB.
module sequenciador_delta #(
    parameter int WIDTH = 4,
    parameter int SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   s,
    output logic                 neg
);

    localparam int PW = 2 * WIDTH;
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (SHIFT > WIDTH) begin : g_bad_shift
        $error("sequenciador_delta: SHIFT must not exceed WIDTH");
    end

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ESCALA,
        SUB,
        FIM
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [PW-1:0]    p_q, p_d;
    logic [PW-1:0]    q_q, q_d;
    logic [PW-1:0]    s_q, s_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        // NOTE: every _d starts as its held value, so no path through the case leaves a latch.
        state_d = state_q;
        b_d     = b_q;
        c_d     = c_q;
        k_d     = k_q;
        p_d     = p_q;
        q_d     = q_q;
        s_d     = s_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE, FIM: begin
                // FIM accepts start too, giving back-to-back operation.
                if (start) begin
                    b_d     = b;
                    c_d     = c;
                    p_d     = '0;
                    k_d     = '0;
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (b_q[k_q]) begin
                    p_d = p_q + (PW'(b_q) << k_q);
                end
                k_d = k_q + KW'(1);
                if (k_q == KW'(WIDTH - 1)) begin
                    state_d = ESCALA;
                end
            end
            ESCALA: begin
                q_d     = PW'(c_q) << SHIFT;
                state_d = SUB;
            end
            SUB: begin
                if (p_q >= q_q) begin
                    s_d   = p_q - q_q;
                    neg_d = 1'b0;
                end else begin
                    s_d   = q_q - p_q;
                    neg_d = 1'b1;
                end
                state_d = FIM;
            end
            default: state_d = IDLE;
        endcase

        // Status flags are decoded from the next state so they are registered with it.
        busy_d = (state_d == MUL) || (state_d == ESCALA) || (state_d == SUB);
        done_d = (state_d == FIM);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            s_q     <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            c_q     <= c_d;
            k_q     <= k_d;
            p_q     <= p_d;
            q_q     <= q_d;
            s_q     <= s_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign neg  = neg_q;

endmodule

// File: doc/sequenciador_delta.md
Name: sequenciador_delta

Overview:
- Multi-cycle sequential version of the |b² − 4c| datapath.
- Uses one internal shift-add multiplier, shared across iterations, instead of two parallel combinational multipliers.
- Iterates b·b, scales c by a power of two, compares, then subtracts larger minus smaller.
- Sits beside the combinational datapath as the area-reduced alternative; a host drives it with a start/done handshake.

Parameters:
- WIDTH, 4: operand width of b and c; result width is 2*WIDTH.
- SHIFT, 2: c is scaled by 2^SHIFT (default gives 4c). Constraint: SHIFT ≤ WIDTH, checked at elaboration.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE or FIM.
- b  input  WIDTH  operand b, captured on accepted start.
- c  input  WIDTH  operand c, captured on accepted start.
- busy  output  1  high while a computation is in progress (MUL, ESCALA, SUB).
- done  output  1  one-cycle pulse; s/neg valid from this cycle on.
- s  output  2*WIDTH  |b² − c·2^SHIFT|.
- neg  output  1  1 when b² < c·2^SHIFT, else 0.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, s=0, neg=0; all internal registers cleared. rst has priority over start and over any state. Reset mid-operation aborts the computation with no done pulse.
- States: IDLE, MUL, ESCALA, SUB, FIM. Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: if start=1, capture b and c, clear accumulator p, set iteration counter k=0, go to MUL. Otherwise stay.
- MUL (exactly WIDTH cycles): on each edge, if bit k of the captured multiplier is 1, then p ← p + (b_reg << k), with width 2*WIDTH and no overflow possible. k ← k+1. After the edge with k=WIDTH−1, go to ESCALA.
- ESCALA (1 cycle): q ← zero-extend(c_reg) << SHIFT, at width 2*WIDTH. Go to SUB.
- SUB (1 cycle):
  - If p ≥ q: s ← p − q, neg ← 0.
  - Else: s ← q − p, neg ← 1.
  - Equality gives s=0, neg=0. Go to FIM.
- FIM (1 cycle): done=1, busy=0.
  - If start=1, capture new operands and go to MUL (back-to-back operation).
  - Else go to IDLE.
- busy=1 exactly in MUL, ESCALA and SUB.
- Latency: start accepted at edge N. done is high during the cycle after edge N+WIDTH+2 (default: 6 edges). Throughput with back-to-back start: one result every WIDTH+3 cycles.
- start during busy is ignored and is not queued. b and c may change freely while busy without affecting the result.
- s and neg hold their last value until the next SUB state; they are not cleared on a new start.
- done never asserts for two consecutive cycles.

Test Plan:
- rst=1 for 2 cycles, then start=1 with b=5, c=3 -> busy high for 6 cycles; done pulses one cycle later; s=13, neg=0.
- b=2, c=3 -> s=8 (12−4), neg=1; then b=4, c=4 -> s=0, neg=0 (equality case).
- b=15, c=15 -> s=165 (225−60), neg=0; b=0, c=15 -> s=60, neg=1 (width extremes).
- start held high continuously with b=5, c=3 -> done pulses every 7 cycles, each with s=13; start pulses and b/c changes while busy do not alter the result or the timing.
- rst=1 asserted during MUL (cycle 2 after start) -> next cycle busy=0, done=0, s=0, neg=0, state=IDLE; no done pulse follows; a fresh start then completes normally.
- Self-checking random loop of 200 (b, c) pairs against the reference model |b² − 4c| and the neg flag, plus a check that exactly one done pulse occurs per accepted start.
